// File: rtl/ram_bist_pkg.sv
// Shared types and March C- element descriptors for the RAM BIST engine.
package ram_bist_pkg;

  typedef enum logic [3:0] {
    IDLE,
    M0,
    M1,
    M2,
    M3,
    M4,
    M5,
    DRAIN,
    DONE
  } state_e;

  // Element descriptors, bit i describes element Mi (bits 6/7 unused).
  localparam logic [7:0] EL_DOWN   = 8'b0001_1000;
  localparam logic [7:0] EL_RD_POL = 8'b0001_0100;
  localparam logic [7:0] EL_WR_POL = 8'b0000_1010;
  localparam logic [7:0] EL_HAS_RD = 8'b0011_1110;
  localparam logic [7:0] EL_HAS_WR = 8'b0001_1111;

  function automatic logic is_elem(state_e s);
    return s inside {M0, M1, M2, M3, M4, M5};
  endfunction

  function automatic logic [2:0] elem_idx(state_e s);
    case (s)
      M1:      return 3'd1;
      M2:      return 3'd2;
      M3:      return 3'd3;
      M4:      return 3'd4;
      M5:      return 3'd5;
      default: return 3'd0;
    endcase
  endfunction

  function automatic state_e next_elem(state_e s);
    case (s)
      M0:      return M1;
      M1:      return M2;
      M2:      return M3;
      M3:      return M4;
      M4:      return M5;
      default: return DRAIN;
    endcase
  endfunction

  function automatic int unsigned depth(int unsigned aw);
    return 32'd1 << aw;
  endfunction

  function automatic int unsigned last_addr(int unsigned aw);
    return depth(aw) - 32'd1;
  endfunction

endpackage

// File: rtl/ram_bist_addr_gen.sv
// Loadable up/down address counter; last_o flags the terminal address for the loaded direction.
module ram_bist_addr_gen
  import ram_bist_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic              down_i,
  input  logic              step_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              last_o
);

  localparam logic [ADDR_W-1:0] TOP = ADDR_W'(last_addr(ADDR_W));

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              down_q, down_d;

  always_comb begin
    addr_d = addr_q;
    down_d = down_q;
    if (load_i) begin
      down_d = down_i;
      addr_d = down_i ? TOP : '0;
    end else if (step_i) begin
      addr_d = down_q ? addr_q - 1'b1 : addr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q <= '0;
      down_q <= 1'b0;
    end else begin
      addr_q <= addr_d;
      down_q <= down_d;
    end
  end

  assign addr_o = addr_q;
  assign last_o = (addr_q == (down_q ? '0 : TOP));

endmodule

// File: rtl/ram_march_bist.sv
// March C- BIST engine: sole initiator of one single-port RAM while busy; reports pass/fail
// and captures the first failing address, read data and expected data.
module ram_march_bist
  import ram_bist_pkg::*;
#(
  parameter int                ADDR_W       = 10,
  parameter int                DATA_W       = 8,
  parameter logic [DATA_W-1:0] BG_PATTERN   = '0,
  parameter int                STOP_ON_FAIL = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data,
  output logic [DATA_W-1:0] fail_exp,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  function automatic logic [DATA_W-1:0] march_data(logic pol);
    return pol ? ~BG_PATTERN : BG_PATTERN;
  endfunction

  state_e            state_q, state_d;
  logic              phase_q, phase_d;
  logic              busy_q, busy_d;
  logic              done_q, fail_q;
  logic              ram_we_q, we_d;
  logic [DATA_W-1:0] ram_din_q, din_d;
  logic [ADDR_W-1:0] fail_addr_q;
  logic [DATA_W-1:0] fail_data_q, fail_exp_q;
  logic              cmp_vld_q;
  logic [DATA_W-1:0] exp_q;
  logic [ADDR_W-1:0] cmp_addr_q;

  logic [2:0]        el_cur, el_nxt;
  logic              in_el, nxt_in_el;
  logic              rd_op, adv, mismatch, start_ok;
  logic              ag_load, ag_down, ag_step, ag_last;
  logic [ADDR_W-1:0] ag_addr;

  ram_bist_addr_gen #(
    .ADDR_W(ADDR_W)
  ) u_addr_gen (
    .clk_i (clk),
    .rst_ni(rst_n),
    .load_i(ag_load),
    .down_i(ag_down),
    .step_i(ag_step),
    .addr_o(ag_addr),
    .last_o(ag_last)
  );

  // phase_q=1 marks the write half of an r,w pair; write-only M0 keeps it set.
  always_comb begin
    el_cur   = elem_idx(state_q);
    in_el    = is_elem(state_q);
    rd_op    = in_el && EL_HAS_RD[el_cur] && !phase_q;
    adv      = in_el && (phase_q || !EL_HAS_WR[el_cur]);
    mismatch = cmp_vld_q && (ram_dout != exp_q);
    start_ok = start && (state_q == IDLE || state_q == DONE);

    state_d = state_q;
    phase_d = phase_q;
    ag_load = 1'b0;
    ag_down = 1'b0;
    ag_step = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = M0;
          phase_d = 1'b1;
          ag_load = 1'b1;
        end
      end
      DRAIN: begin
        state_d = DONE;
        ag_load = 1'b1;
      end
      default: begin
        if (adv && ag_last) begin
          state_d = next_elem(state_q);
          ag_load = 1'b1;
          ag_down = EL_DOWN[elem_idx(state_d)];
          phase_d = !EL_HAS_RD[elem_idx(state_d)];
        end else begin
          ag_step = adv;
          if (EL_HAS_RD[el_cur] && EL_HAS_WR[el_cur]) phase_d = !phase_q;
        end
      end
    endcase

    if (STOP_ON_FAIL != 0 && mismatch) begin
      state_d = DONE;
      ag_load = 1'b1;
      ag_down = 1'b0;
    end

    // Outputs are registered from the next-cycle operation.
    el_nxt    = elem_idx(state_d);
    nxt_in_el = is_elem(state_d);
    we_d      = nxt_in_el && EL_HAS_WR[el_nxt] && phase_d;
    din_d     = we_d ? march_data(EL_WR_POL[el_nxt]) : '0;
    busy_d    = nxt_in_el || (state_d == DRAIN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      phase_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_din_q   <= '0;
      fail_addr_q <= '0;
      fail_data_q <= '0;
      fail_exp_q  <= '0;
      cmp_vld_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      busy_q    <= busy_d;
      ram_we_q  <= we_d;
      ram_din_q <= din_d;
      cmp_vld_q <= rd_op && (state_d != DONE);
      if (start_ok) begin
        done_q      <= 1'b0;
        fail_q      <= 1'b0;
        fail_addr_q <= '0;
        fail_data_q <= '0;
        fail_exp_q  <= '0;
      end else begin
        if (state_d == DONE && state_q != DONE) done_q <= 1'b1;
        if (mismatch) begin
          fail_q <= 1'b1;
          if (!fail_q) begin
            fail_addr_q <= cmp_addr_q;
            fail_data_q <= ram_dout;
            fail_exp_q  <= exp_q;
          end
        end
      end
    end
  end

  // Expected data and address of a read, consumed one cycle later when ram_dout returns.
  always_ff @(posedge clk) begin
    if (rd_op) begin
      exp_q      <= march_data(EL_RD_POL[el_cur]);
      cmp_addr_q <= ag_addr;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign fail      = fail_q;
  assign fail_addr = fail_addr_q;
  assign fail_data = fail_data_q;
  assign fail_exp  = fail_exp_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ag_addr;
  assign ram_din   = ram_din_q;

endmodule
